// File: rtl/instrumented_adder_meas.sv
// Measurement controller for instrumented adder cores: drives operands, gates one ring oscillator
// for a programmed window and counts its edges. Define INSTR_ADDER_CHECK_EN to build the sum checker.
module instrumented_adder_meas #(
   parameter int  WIDTH    = 32,
   parameter int  CHANNELS = 4,
   parameter int  CNT_W    = 24,
   parameter int  WIN_W    = 16,
   parameter int  SETTLE   = 4,
   localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      start_i,
   input  logic [SEL_W-1:0]          chan_sel_i,
   input  logic [WIDTH-1:0]          a_i,
   input  logic [WIDTH-1:0]          b_i,
   input  logic [WIN_W-1:0]          window_i,
   output logic [WIDTH-1:0]          a_o,
   output logic [WIDTH-1:0]          b_o,
   output logic [CHANNELS-1:0]       ring_en_o,
   input  logic [CHANNELS-1:0]       ring_i,
   input  logic [CHANNELS*WIDTH-1:0] sum_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [CNT_W-1:0]          count_o,
   output logic [WIDTH-1:0]          sum_o,
   output logic                      bad_chan_o,
   output logic                      error_o
);

   localparam int SET_W  = $clog2(SETTLE + 1);
   localparam int TMR_W0 = (WIN_W > SET_W) ? WIN_W : SET_W;
   localparam int TMR_W  = (TMR_W0 > 2) ? TMR_W0 : 2;
   localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
   localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(2);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_CAPTURE = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [TMR_W-1:0]    tmr_r;
   logic [TMR_W-1:0]    tmr_nxt_s;
   logic [WIDTH-1:0]    a_r;
   logic [WIDTH-1:0]    b_r;
   logic [SEL_W-1:0]    sel_r;
   logic [WIN_W-1:0]    win_r;
   logic [CHANNELS-1:0] onehot_s;
   logic                sel_ok_s;
   logic                tap_s;
   logic [WIDTH-1:0]    sum_sel_s;
   logic                sync1_r;
   logic                sync2_r;
   logic                prev_r;
   logic                edge_s;
   logic                count_win_s;
   logic                start_acc_s;
   logic                capture_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [CHANNELS-1:0] ring_en_r;
   logic                busy_r;
   logic                done_r;
   logic [CNT_W-1:0]    count_r;
   logic [WIDTH-1:0]    sum_r;
   logic                bad_r;

   assign start_acc_s = (state_r == ST_IDLE) && start_i;
   assign capture_s   = (state_r == ST_CAPTURE);
   assign count_win_s = (state_r == ST_RUN) || (state_r == ST_DRAIN);
   assign sel_ok_s    = |onehot_s;
   assign edge_s      = sync2_r & ~prev_r;

   // Channel decode: one-hot enable, oscillator tap and sum slice of the latched channel
   always_comb begin
      onehot_s  = {CHANNELS{1'b0}};
      tap_s     = 1'b0;
      sum_sel_s = {WIDTH{1'b0}};
      for (int n = 0; n < CHANNELS; n++) begin
         onehot_s[n] = (sel_r == SEL_W'(n));
         tap_s       = (sel_r == SEL_W'(n)) ? ring_i[n] : tap_s;
         sum_sel_s   = (sel_r == SEL_W'(n)) ? sum_i[n*WIDTH +: WIDTH] : sum_sel_s;
      end
   end

   // Next-state and phase timer; timer is loaded with (length-1) and the phase ends at zero
   always_comb begin
      state_nxt_s = state_r;
      tmr_nxt_s   = tmr_r;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               state_nxt_s = ST_LOAD;
               tmr_nxt_s   = SETTLE_LD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (!sel_ok_s) begin
               state_nxt_s = ST_CAPTURE;
            end else if (tmr_r != TMR_ZERO) begin
               tmr_nxt_s = tmr_r - TMR_ONE;
            end else if (win_r == {WIN_W{1'b0}}) begin
               state_nxt_s = ST_DRAIN;
               tmr_nxt_s   = DRAIN_LD;
            end else begin
               state_nxt_s = ST_RUN;
               tmr_nxt_s   = TMR_W'(win_r) - TMR_ONE;
            end
         end
         ST_RUN: begin
            if (tmr_r != TMR_ZERO) begin
               tmr_nxt_s = tmr_r - TMR_ONE;
            end else begin
               state_nxt_s = ST_DRAIN;
               tmr_nxt_s   = DRAIN_LD;
            end
         end
         ST_DRAIN: begin
            if (tmr_r != TMR_ZERO) begin
               tmr_nxt_s = tmr_r - TMR_ONE;
            end else begin
               state_nxt_s = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            state_nxt_s = ST_IDLE;
            tmr_nxt_s   = TMR_ZERO;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            tmr_nxt_s   = TMR_ZERO;
         end
      endcase
   end

   // State and timer registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_r <= ST_IDLE;
         tmr_r   <= TMR_ZERO;
      end else begin
         state_r <= state_nxt_s;
         tmr_r   <= tmr_nxt_s;
      end
   end

   // Request latches; operands stay on a_o/b_o until the next accepted start
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         a_r   <= {WIDTH{1'b0}};
         b_r   <= {WIDTH{1'b0}};
         sel_r <= {SEL_W{1'b0}};
         win_r <= {WIN_W{1'b0}};
      end else if (start_acc_s) begin
         a_r   <= a_i;
         b_r   <= b_i;
         sel_r <= chan_sel_i;
         win_r <= window_i;
      end else begin
         a_r   <= a_r;
         b_r   <= b_r;
         sel_r <= sel_r;
         win_r <= win_r;
      end
   end

   // Two-flop synchroniser on the selected tap plus a history flop for rising-edge detection
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
      end else begin
         sync1_r <= tap_s;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Saturating edge counter, live in RUN and DRAIN only
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (start_acc_s) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (count_win_s && edge_s && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Registered outputs, decoded from the next state so they align with the state itself
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ring_en_r <= {CHANNELS{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         ring_en_r <= (state_nxt_s == ST_RUN) ? onehot_s : {CHANNELS{1'b0}};
         busy_r    <= (state_nxt_s != ST_IDLE);
         done_r    <= capture_s;
      end
   end

   // Result registers, held until the next measurement captures
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         count_r <= {CNT_W{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         bad_r   <= 1'b0;
      end else if (start_acc_s) begin
         count_r <= count_r;
         sum_r   <= sum_r;
         bad_r   <= 1'b0;
      end else if (capture_s) begin
         count_r <= cnt_r;
         sum_r   <= sum_sel_s;
         bad_r   <= ~sel_ok_s;
      end else begin
         count_r <= count_r;
         sum_r   <= sum_r;
         bad_r   <= bad_r;
      end
   end

`ifdef INSTR_ADDER_CHECK_EN
   function automatic logic sum_mismatch(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] ref_sum;
      ref_sum = a + b;
      return (ref_sum != s);
   endfunction

   logic error_r;

   // Sum checker: flags a core whose result differs from the modular sum
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         error_r <= 1'b0;
      end else if (start_acc_s) begin
         error_r <= 1'b0;
      end else if (capture_s) begin
         error_r <= sel_ok_s & sum_mismatch(a_r, b_r, sum_sel_s);
      end else begin
         error_r <= error_r;
      end
   end

   assign error_o = error_r;
`else
   assign error_o = 1'b0;
`endif

   assign a_o        = a_r;
   assign b_o        = b_r;
   assign ring_en_o  = ring_en_r;
   assign busy_o     = busy_r;
   assign done_o     = done_r;
   assign count_o    = count_r;
   assign sum_o      = sum_r;
   assign bad_chan_o = bad_r;

endmodule

// File: tb/tb_instrumented_adder_meas.sv
// Directed bench for instrumented_adder_meas: a default 4-channel instance plus a
// 3-channel, 4-bit-counter instance for the bad-channel and saturation cases.
module tb_instrumented_adder_meas;

   localparam int  HALF1 = 2;
   localparam int  HALF2 = 1;
`ifdef INSTR_ADDER_CHECK_EN
   localparam bit  CHK = 1'b1;
`else
   localparam bit  CHK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start1 = 1'b0;
   logic         start2 = 1'b0;
   logic [1:0]   chan = 2'd0;
   logic [31:0]  a = 32'd0;
   logic [31:0]  b = 32'd0;
   logic [15:0]  window = 16'd0;

   logic [31:0]  a1, b1, sum_o1;
   logic [3:0]   ren1;
   logic [3:0]   ring1 = 4'b0000;
   logic [127:0] sum1 = {32'hDDDD_0003, 32'hCCCC_0002, 32'h2345_6789, 32'hAAAA_0000};
   logic         busy1, done1, bad1, err1;
   logic [23:0]  cnt1;

   logic [31:0]  a2, b2, sum_o2;
   logic [2:0]   ren2;
   logic [2:0]   ring2 = 3'b000;
   logic [95:0]  sum2 = {32'h0000_0009, 32'h0000_0008, 32'h0000_0007};
   logic         busy2, done2, bad2, err2;
   logic [3:0]   cnt2;

   int n_checks = 0;
   int n_errors = 0;
   int ph = 0;

   instrumented_adder_meas dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start1), .chan_sel_i(chan),
      .a_i(a), .b_i(b), .window_i(window), .a_o(a1), .b_o(b1),
      .ring_en_o(ren1), .ring_i(ring1), .sum_i(sum1), .busy_o(busy1), .done_o(done1),
      .count_o(cnt1), .sum_o(sum_o1), .bad_chan_o(bad1), .error_o(err1)
   );

   instrumented_adder_meas #(.CHANNELS(3), .CNT_W(4)) dut2 (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start2), .chan_sel_i(chan),
      .a_i(a), .b_i(b), .window_i(window), .a_o(a2), .b_o(b2),
      .ring_en_o(ren2), .ring_i(ring2), .sum_i(sum2), .busy_o(busy2), .done_o(done2),
      .count_o(cnt2), .sum_o(sum_o2), .bad_chan_o(bad2), .error_o(err2)
   );

   always #5 clk = ~clk;

   // Ring oscillator models: run only while enabled; ring1[3] is free-running noise
   always @(negedge clk) begin
      ph <= ph + 1;
      for (int c = 0; c < 3; c++) begin
         if (ren1[c] && (ph % HALF1 == 0)) ring1[c] <= ~ring1[c];
         if (ren2[c] && (ph % HALF2 == 0)) ring2[c] <= ~ring2[c];
      end
      ring1[3] <= ~ring1[3];
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic measure(input bit use2, input logic [1:0] s, input logic [15:0] w,
                          input logic [31:0] aa, input logic [31:0] bb,
                          output int lat, output int en_cyc, output int en_bad);
      logic [3:0] en_now;
      logic [3:0] en_exp;
      en_exp = 4'b0001 << s;
      @(negedge clk);
      a = aa; b = bb; window = w; chan = s;
      if (use2) start2 = 1'b1; else start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; start2 = 1'b0;
      check_eq("busy_after_start", 64'(use2 ? busy2 : busy1), 64'(1));
      lat = 0; en_cyc = 0; en_bad = 0;
      while (!(use2 ? done2 : done1) && lat < 400) begin
         @(posedge clk); #1;
         lat++;
         en_now = use2 ? {1'b0, ren2} : ren1;
         if (en_now != 4'b0000) en_cyc++;
         if ((en_now != 4'b0000) && (en_now != en_exp)) en_bad++;
      end
      check_eq("busy_at_done", 64'(use2 ? busy2 : busy1), 64'(0));
   endtask

   initial begin
      int lat, en_cyc, en_bad, ndone, t_first, t_second;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 64'(busy1), 64'(0));
      check_eq("rst_done", 64'(done1), 64'(0));
      check_eq("rst_ring_en", 64'(ren1), 64'(0));
      check_eq("rst_count", 64'(cnt1), 64'(0));
      check_eq("rst_outs", 64'({a1, b1} | {32'd0, sum_o1}), 64'(0));
      check_eq("rst_flags", 64'({bad1, err1}), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      // Channel 1, window 64, ring period 4 clocks
      measure(1'b0, 2'd1, 16'd64, 32'h1234_5678, 32'h1111_1111, lat, en_cyc, en_bad);
      check_eq("w64_latency", 64'(lat), 64'(72));
      check_eq("w64_count_16pm1", 64'((cnt1 >= 24'd15) && (cnt1 <= 24'd17)), 64'(1));
      check_eq("w64_en_cycles", 64'(en_cyc), 64'(64));
      check_eq("w64_en_onehot", 64'(en_bad), 64'(0));
      check_eq("w64_sum", 64'(sum_o1), 64'(32'h2345_6789));
      check_eq("w64_operands", {a1, b1}, {32'h1234_5678, 32'h1111_1111});
      check_eq("w64_error", 64'(err1), 64'(0));
      @(posedge clk); #1;
      check_eq("done_one_cycle", 64'(done1), 64'(0));
      check_eq("count_holds", 64'((cnt1 >= 24'd15) && (cnt1 <= 24'd17)), 64'(1));

      // Async reset at cycle 20 of a 100-cycle RUN
      @(negedge clk);
      a = 32'h5; b = 32'h6; window = 16'd100; chan = 2'd1; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (24) @(posedge clk);
      #2;
      check_eq("pre_rst_ring_en", 64'(ren1), 64'(4'b0010));
      rst = 1'b1;
      #1;
      check_eq("midrst_ring_en", 64'(ren1), 64'(0));
      check_eq("midrst_busy", 64'(busy1), 64'(0));
      check_eq("midrst_outs", 64'({a1, b1} | {32'd0, sum_o1} | {40'd0, cnt1}), 64'(0));
      check_eq("midrst_flags", 64'({done1, bad1, err1}), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 120; i++) begin
         @(posedge clk); #1;
         if (done1 || (ren1 != 4'b0000)) ndone++;
      end
      check_eq("midrst_no_done", 64'(ndone), 64'(0));

      // Window 0 on channel 2: no RUN phase at all
      measure(1'b0, 2'd2, 16'd0, 32'd0, 32'd0, lat, en_cyc, en_bad);
      check_eq("w0_latency", 64'(lat), 64'(8));
      check_eq("w0_count", 64'(cnt1), 64'(0));
      check_eq("w0_en_cycles", 64'(en_cyc), 64'(0));
      check_eq("w0_sum", 64'(sum_o1), 64'(32'hCCCC_0002));
      check_eq("w0_error", 64'(err1), 64'(CHK));

      // Out-of-range channel on the 3-channel instance
      measure(1'b1, 2'd3, 16'd10, 32'd1, 32'd2, lat, en_cyc, en_bad);
      check_eq("bad_latency", 64'(lat), 64'(2));
      check_eq("bad_flag", 64'(bad2), 64'(1));
      check_eq("bad_count", 64'(cnt2), 64'(0));
      check_eq("bad_en_cycles", 64'(en_cyc), 64'(0));

      // Counter saturation: 4-bit counter, window 100, ring period 2
      measure(1'b1, 2'd0, 16'd100, 32'd3, 32'd4, lat, en_cyc, en_bad);
      check_eq("sat_latency", 64'(lat), 64'(108));
      check_eq("sat_count", 64'(cnt2), 64'(15));
      check_eq("sat_bad_cleared", 64'(bad2), 64'(0));
      check_eq("sat_sum", 64'(sum_o2), 64'(32'h0000_0007));
      check_eq("sat_en_cycles", 64'(en_cyc), 64'(100));

      // Sum checker: wrap-around sum correct, then wrong
      sum1[63:32] = 32'h0000_0000;
      measure(1'b0, 2'd1, 16'd4, 32'hFFFF_FFFF, 32'h0000_0001, lat, en_cyc, en_bad);
      check_eq("chk_wrap_ok", 64'(err1), 64'(0));
      check_eq("chk_wrap_latency", 64'(lat), 64'(12));
      sum1[63:32] = 32'h0000_0001;
      measure(1'b0, 2'd1, 16'd4, 32'hFFFF_FFFF, 32'h0000_0001, lat, en_cyc, en_bad);
      check_eq("chk_wrap_bad", 64'(err1), 64'(CHK));
      check_eq("chk_sum_out", 64'(sum_o1), 64'(1));

      // start_i held high: one done per measurement, restart the cycle after return to IDLE
      @(negedge clk);
      a = 32'd7; b = 32'd8; window = 16'd2; chan = 2'd1; start1 = 1'b1;
      ndone = 0; t_first = -1; t_second = -1;
      for (int i = 0; i < 56; i++) begin
         @(posedge clk); #1;
         if (done1) begin
            ndone++;
            if (t_first < 0) t_first = i;
            else if (t_second < 0) t_second = i;
         end
      end
      start1 = 1'b0;
      check_eq("held_done_count", 64'(ndone), 64'(5));
      check_eq("held_first_done", 64'(t_first), 64'(10));
      check_eq("held_restart_gap", 64'(t_second - t_first), 64'(11));
      lat = 0;
      while (!done1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("held_final_done", 64'(done1), 64'(1));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/instrumented_adder_meas.md
# instrumented_adder_meas

Parametrised measurement controller for instrumented adder cores. It drives operands into one of `CHANNELS` adder instances and enables that channel's ring oscillator for a programmable window of `wb_clk_i` cycles. It counts synchronised oscillator rising edges and captures the adder sum. It sits between the logic-analyser register bank and the adder cores, and replaces the fixed single-core 32-bit arrangement with a width-, channel- and window-configurable engine.

## Interface
Parameters:
- `WIDTH`, 32, operand/sum width
- `CHANNELS`, 4, number of adder cores (ripple, kogge, sklansky, brent-kung); min 1
- `CNT_W`, 24, edge-counter width
- `WIN_W`, 16, window-length register width
- `SETTLE`, 4, operand settle cycles before ring enable; min 1

Ports:
- `wb_clk_i` in 1: single clock
- `wb_rst_i` in 1: reset, asynchronous, active-high
- `start_i` in 1: level, sampled in IDLE
- `chan_sel_i` in clog2(CHANNELS) (min 1): channel under test
- `a_i`, `b_i` in WIDTH: operands
- `window_i` in WIN_W: RUN length in cycles
- `a_o`, `b_o` out WIDTH: operands to all cores
- `ring_en_o` out CHANNELS: one-hot oscillator enable
- `ring_i` in CHANNELS: asynchronous oscillator taps
- `sum_i` in CHANNELS*WIDTH: core sums, channel n at [n*WIDTH +: WIDTH]
- `busy_o` out 1, `done_o` out 1 (one-cycle pulse)
- `count_o` out CNT_W, `sum_o` out WIDTH
- `bad_chan_o` out 1, `error_o` out 1

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, CAPTURE.
- IDLE, `start_i`=1:
  - Latch `a_i`, `b_i`, `chan_sel_i` and `window_i`.
  - Clear the counter, `bad_chan_o` and `error_o`.
  - Go to LOAD.
- If the latched channel is ≥ CHANNELS: go directly to CAPTURE, set `bad_chan_o`=1, leave `count_o`=0, and keep `ring_en_o` at 0.
- LOAD:
  - `a_o`/`b_o` are driven from the latches and held stable until the next start.
  - Stay SETTLE cycles, then go to RUN; if the latched window is 0, go to DRAIN instead.
- RUN:
  - `ring_en_o[sel]`=1.
  - Stay exactly window cycles, then go to DRAIN.
- DRAIN:
  - `ring_en_o`=0.
  - Stay 3 cycles so edges already in the synchroniser are counted.
- CAPTURE:
  - One cycle.
  - Register `count_o` and `sum_o` (`sum_i` slice of sel).
  - Go to IDLE and pulse `done_o`.
- Edge detection:
  - `ring_i[sel]` passes through a 2-flop synchroniser plus a previous-value flop.
  - A rising edge increments the counter during RUN and DRAIN only.
  - The counter saturates at 2^CNT_W−1 and does not wrap.
- `start_i` outside IDLE is ignored. A `start_i` still held high on return to IDLE starts a new measurement on the next cycle.
- `count_o`, `sum_o`, `bad_chan_o` and `error_o` hold their values until the next start.
- Only the selected channel's synchroniser feeds the counter; all other `ring_i` bits are ignored.

## Timing
- Reset values: all outputs 0; FSM = IDLE. Async reset mid-operation drops `ring_en_o` immediately, with no done pulse.
- Start sampled at edge k: `busy_o`=1 from k+1 through the CAPTURE cycle.
- Latency from edge k to `done_o` high is SETTLE + window + 4 cycles (window 0: SETTLE + 4). Bad channel: 2 cycles.
- `done_o` is high for exactly one cycle, coincident with `busy_o`=0 and with the new results visible.
- `ring_en_o` is high for exactly window consecutive cycles.

## Configuration
- Macro: `INSTR_ADDER_CHECK_EN`.
- Defined:
  - CAPTURE compares `sum_i[sel]` with (a+b) mod 2^WIDTH.
  - `error_o`=1 on mismatch.
- Undefined:
  - No comparator is built.
  - `error_o` is tied 0.

## Test plan
- Reset while in RUN (window=100, cycle 20 of RUN) → `ring_en_o`=0 and `busy_o`=0 at once; no `done_o`; all outputs 0.
- WIDTH=32, ch1, SETTLE=4, window=64, `ring_i[1]` period 4 clocks → `done_o` exactly 72 cycles after start; `count_o`=16±1; `ring_en_o`=4'b0010 for 64 cycles.
- window=0 → `done_o` 8 cycles after start; `count_o`=0; `ring_en_o` never asserted.
- CHANNELS=3, `chan_sel_i`=3 → `bad_chan_o`=1, `count_o`=0, `done_o` 2 cycles after start.
- CNT_W=4, window=100, ring period 2 → `count_o`=15 (saturated).
- CHECK_EN, a=32'hFFFFFFFF, b=1, `sum_i`=0 → `error_o`=0. Then `sum_i`=1 → `error_o`=1; without the macro `error_o`=0. Also hold `start_i` high through busy → exactly one done per measurement and back-to-back restarts.
